sin_sampler: RTL
================

# sin_sampler

Clocked sampling and quantization stage placed directly downstream of the real-valued sine source. It samples the `real` input every `DECIM` clocks and converts it to a saturated two's-complement code. Codes are buffered in a 4-entry FIFO behind a valid/ready output. Alongside the FIFO, it measures the signal period in samples between rising zero crossings.

## Interface
- `BITS`, 8: output code width (2..16).
- `VREF`, 1.0 (real): input amplitude mapping to full-scale code.
- `DECIM`, 1: clocks per sample (1..256).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in`  in  real  analog input value (realnet-compatible).
- `out_data`  out  BITS  FIFO head code, two's complement.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head.
- `clip`  out  1  sticky: a sample saturated.
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full.
- `period`  out  16  samples between the last two rising zero crossings.
- `period_valid`  out  1  one-cycle pulse when `period` updates.

## Operation
- Decimation counter `dcnt`, range 0..DECIM-1.
  - Counts up every cycle.
  - The sample edge is the edge where `dcnt==DECIM-1`; `dcnt` wraps to 0 on that edge.
  - With `DECIM=1`, every edge is a sample edge.
- Quantization on a sample edge:
  - Scale: x = in/VREF*(2^(BITS-1)-1).
  - Round half away from zero.
  - Saturate to [-2^(BITS-1), 2^(BITS-1)-1]. If saturation changed the value, set `clip` (sticky).
  - NaN input is treated as 0.
- FIFO: 4 entries, first-word-fall-through.
  - Push on every sample edge.
  - Pop when `out_valid && out_ready`.
  - Push and pop on the same edge are both honoured, including when full; occupancy is unchanged.
  - Push when full with no pop: the sample is dropped, FIFO contents are unchanged, and `overflow` is set (sticky).
  - Pop when empty is impossible, because `out_valid` is low.
- Zero-crossing tracker, updated on sample edges only:
  - Keeps the previous code `prev` and a 16-bit sample counter `scnt`. `scnt` saturates at 65535.
  - A rising crossing is `prev<0 && code>=0`.
  - On a crossing, if `armed`: `period<=scnt+1`, pulse `period_valid`, `scnt<=0`.
  - On a crossing when not armed: set `armed`, `scnt<=0`, no pulse. This means the first crossing after reset never reports.
  - Otherwise `scnt<=scnt+1`.
  - `prev` resets to 0, so the first sample cannot form a crossing.
- Reset, effective from any state, including mid-transfer:
  - `out_valid=0` and `out_data=0`; the FIFO is emptied.
  - `clip=0`, `overflow=0`, `period=0`, `period_valid=0`.
  - `dcnt=0`, `scnt=0`, `prev=0`, `armed=0`.
  - Data in flight is discarded.

## Timing
- `in` is read at the sample edge. Its value settles before the edge is taken (delta ordering).
- Latency: sample edge N → `out_valid=1` with the code on `out_data` after edge N, provided the FIFO was empty.
- `out_data` is stable while `out_valid && !out_ready`.
- The next entry appears the cycle after a pop.
- `out_data` holds its last value when empty. This value is don't-care for checkers.
- `clip` and `overflow` assert the cycle after the offending sample edge.
- `period_valid` is high for exactly the one cycle following the crossing sample edge. `period` is updated in that same cycle and held afterwards.
- The first sample after reset release occurs at edge DECIM after `rst` deasserts.

## Test plan
- DC quantization, `BITS=8`, `VREF=1.0`, `DECIM=1`, `out_ready=1`:
  - in=0.5 → 64.
  - in=-0.25 → -32.
  - in=0.0 → 0.
  - In all three cases `clip=0`.
- Saturation:
  - in=1.2 → 127 and `clip=1`.
  - in=-1.5 → -128.
  - `clip` stays 1 when in returns to 0.3; only `rst` clears it.
- Backpressure, `out_ready=0`, DECIM=1, in ramps through codes 1..6:
  - FIFO holds 1..4 and `overflow=1` after the 5th sample.
  - Raising `out_ready` drains 1,2,3,4 in order, then new samples.
- Decimation, `DECIM=4`, in=0.5:
  - `out_valid` first rises after the 4th edge following reset release.
  - One push every 4 clocks.
- Period measurement, sine source at 1 GHz with 20 points/cycle, sampled at 20 GS/s, DECIM=1:
  - No `period_valid` on the first rising crossing.
  - Every subsequent crossing reports `period=20`.
- Reset mid-operation: assert `rst` for one cycle while the FIFO holds 3 entries and `overflow=1`:
  - Next cycle shows all outputs 0 and `out_valid=0`.
  - The first sample after release is correct.

Source files
------------

// File: rtl/sin_sampler.sv
// Sampling/quantization stage for a real-valued sine source: decimates, quantizes with
// saturation, buffers codes in a 4-entry FWFT FIFO and measures rising-crossing period.
module sin_sampler #(
  parameter int  BITS  = 8,
  parameter real VREF  = 1.0,
  parameter int  DECIM = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  real             in,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            clip,
  output logic            overflow,
  output logic [15:0]     period,
  output logic            period_valid
);

  localparam int         MAXC  = (2 ** (BITS - 1)) - 1;
  localparam int         MINC  = -(2 ** (BITS - 1));
  localparam logic [7:0] DLAST = 8'(DECIM - 1);

  // Returns {saturated, code}; NaN maps to zero, rounding is half away from zero.
  function automatic logic [BITS:0] quantize(input real v);
    real x;
    real r;
    logic [BITS:0] res;
    x = (v != v) ? 0.0 : v / VREF * real'(MAXC);
    r = (x >= 0.0) ? $floor(x + 0.5) : -$floor(0.5 - x);
    if (r > real'(MAXC)) begin
      res = {1'b1, BITS'(MAXC)};
    end else if (r < real'(MINC)) begin
      res = {1'b1, BITS'(MINC)};
    end else begin
      res = {1'b0, BITS'($rtoi(r))};
    end
    return res;
  endfunction

  logic [7:0]      dcnt_r;
  logic [BITS-1:0] mem_r [4];
  logic [1:0]      wr_r;
  logic [1:0]      rd_r;
  logic [2:0]      cnt_r;
  logic [BITS-1:0] prev_r;
  logic [15:0]     scnt_r;
  logic            armed_r;

  logic            sample_s;
  logic            clip_s;
  logic [BITS-1:0] code_s;
  logic            rise_s;
  logic            pop_s;
  logic            full_s;
  logic            wr_en_s;
  logic [2:0]      cnt_nxt_s;
  logic [1:0]      rd_nxt_s;
  logic [BITS-1:0] head_nxt_s;

  // Sample strobe, quantizer and crossing detector.
  always_comb begin
    sample_s         = (dcnt_r == DLAST);
    {clip_s, code_s} = quantize(in);
    rise_s           = prev_r[BITS-1] && !code_s[BITS-1];
  end

  // FIFO next-state; a push when full is only accepted alongside a pop.
  always_comb begin
    pop_s     = out_valid && out_ready;
    full_s    = (cnt_r == 3'd4);
    wr_en_s   = sample_s && (!full_s || pop_s);
    cnt_nxt_s = cnt_r + {2'b00, wr_en_s} - {2'b00, pop_s};
    rd_nxt_s  = rd_r + {1'b0, pop_s};
    if (wr_en_s && (wr_r == rd_nxt_s)) begin
      head_nxt_s = code_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // All state: decimation, FIFO, sticky flags and period tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_r       <= 8'd0;
      for (int i = 0; i < 4; i++) mem_r[i] <= '0;
      wr_r         <= 2'd0;
      rd_r         <= 2'd0;
      cnt_r        <= 3'd0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      clip         <= 1'b0;
      overflow     <= 1'b0;
      period       <= 16'd0;
      period_valid <= 1'b0;
      prev_r       <= '0;
      scnt_r       <= 16'd0;
      armed_r      <= 1'b0;
    end else begin
      dcnt_r <= sample_s ? 8'd0 : dcnt_r + 8'd1;
      if (wr_en_s) begin
        mem_r[wr_r] <= code_s;
        wr_r        <= wr_r + 2'd1;
      end
      rd_r      <= rd_nxt_s;
      cnt_r     <= cnt_nxt_s;
      out_valid <= (cnt_nxt_s != 3'd0);
      if (cnt_nxt_s != 3'd0) begin
        out_data <= head_nxt_s;
      end
      if (sample_s && clip_s) begin
        clip <= 1'b1;
      end
      if (sample_s && full_s && !pop_s) begin
        overflow <= 1'b1;
      end
      period_valid <= 1'b0;
      if (sample_s) begin
        prev_r <= code_s;
        if (rise_s) begin
          // The first crossing after reset only arms the tracker.
          if (armed_r) begin
            period       <= (scnt_r == 16'hffff) ? 16'hffff : scnt_r + 16'd1;
            period_valid <= 1'b1;
          end
          armed_r <= 1'b1;
          scnt_r  <= 16'd0;
        end else if (scnt_r != 16'hffff) begin
          scnt_r <= scnt_r + 16'd1;
        end
      end
    end
  end

endmodule
